// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and receiver/transmitter state encoding.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in and received-byte status out of the UART receiver.
interface uart_rx_if #(
   parameter int unsigned DATA_BITS = uart_pkg::UART_DATA_BITS
) ();

   logic                 rx;
   logic [DATA_BITS-1:0] Rx_Data;
   logic                 Rx_Valid;
   logic                 Rx_FrameErr;
   logic                 Rx_Busy;

   // master drives the line and consumes bytes; slave is the receiver
   modport master (output rx, input Rx_Data, Rx_Valid, Rx_FrameErr, Rx_Busy);
   modport slave  (input rx, output Rx_Data, Rx_Valid, Rx_FrameErr, Rx_Busy);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification, mid-bit sampling, stop check.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = UART_DATA_BITS,
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       Rx_Clk,
   uart_rx_if.slave   rx_if
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 rx_clk_q;
   logic                 tick_c;
   uart_state_e          state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [BIT_W-1:0]     bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 ferr_q;
   logic                 busy_q;

   uart_sync2 #(.RST_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d_i   (rx_if.rx),
      .q_o   (rx_s)
   );

   // Rx_Clk is only sampled as data; its rising edge becomes a one-clk tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rx_clk_q <= 1'b0;
      else          rx_clk_q <= Rx_Clk;
   end

   assign tick_c = Rx_Clk & ~rx_clk_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         if (tick_c) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (!rx_s) begin
                     state_q <= ST_START;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               // re-check the line half a bit in; a high here was a glitch
               ST_START: begin
                  if (cnt_q == HALF_LAST) begin
                     cnt_q <= '0;
                     if (!rx_s) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                     end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_DATA: begin
                  if (cnt_q == FULL_LAST) begin
                     cnt_q   <= '0;
                     shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                     if (bit_q == LAST_BIT) state_q <= ST_STOP;
                     else                   bit_q   <= bit_q + BIT_W'(1);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_STOP: begin
                  if (cnt_q == FULL_LAST) begin
                     cnt_q <= '0;
                     if (rx_s) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        ferr_q  <= 1'b1;
                        state_q <= ST_BREAK;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_BREAK: begin
                  if (rx_s) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx_if.Rx_Data     = data_q;
   assign rx_if.Rx_Valid    = valid_q;
   assign rx_if.Rx_FrameErr = ferr_q;
   assign rx_if.Rx_Busy     = busy_q;

   a_pulse_excl: assert property (@(posedge clk) disable iff (!reset_n) !(valid_q && ferr_q));

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, glitch, framing error, back-to-back, reset abort, baud skew.
module tb_uart_rx;

   localparam int unsigned BIT = 1920;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic Rx_Clk  = 1'b0;

   uart_rx_if bus ();

   uart_rx dut (
      .clk     (clk),
      .reset_n (reset_n),
      .Rx_Clk  (Rx_Clk),
      .rx_if   (bus)
   );

   // clk period 10, Rx_Clk period 120 (12 clk); Rx_Clk edges fall on clk negedges
   always #5  clk    = ~clk;
   always #60 Rx_Clk = ~Rx_Clk;

   int total = 0;
   int bad   = 0;

   int valid_cnt = 0;
   int ferr_cnt  = 0;
   int both_cnt  = 0;
   int long_cnt  = 0;
   logic prev_v  = 1'b0;
   logic prev_f  = 1'b0;
   logic [7:0] rxq [$];

   always @(negedge clk) begin
      if (bus.Rx_Valid) begin
         valid_cnt <= valid_cnt + 1;
         rxq.push_back(bus.Rx_Data);
      end
      if (bus.Rx_FrameErr)                 ferr_cnt <= ferr_cnt + 1;
      if (bus.Rx_Valid && bus.Rx_FrameErr) both_cnt <= both_cnt + 1;
      if ((bus.Rx_Valid && prev_v) || (bus.Rx_FrameErr && prev_f)) long_cnt <= long_cnt + 1;
      prev_v <= bus.Rx_Valid;
      prev_f <= bus.Rx_FrameErr;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] q_at(input int idx);
      if (idx < rxq.size()) return 32'(rxq[idx]);
      return 32'hDEAD;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input int unsigned bit_t);
      bus.rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         #(bit_t);
      end
      bus.rx = stop_b;
      #(bit_t);
      bus.rx = 1'b1;
   endtask

   int v0, f0, q0;

   initial begin
      bus.rx = 1'b1;
      #100;
      @(negedge clk);
      check("rst_data",  32'(bus.Rx_Data), 32'h0);
      check("rst_valid", 32'(bus.Rx_Valid), 32'h0);
      check("rst_ferr",  32'(bus.Rx_FrameErr), 32'h0);
      check("rst_busy",  32'(bus.Rx_Busy), 32'h0);
      reset_n = 1'b1;
      #(2 * BIT);

      // single good frame
      v0 = valid_cnt; f0 = ferr_cnt; q0 = rxq.size();
      send_frame(8'hA5, 1'b1, BIT);
      #(BIT / 2);
      @(negedge clk);
      check("a5_vcnt", 32'(valid_cnt - v0), 32'd1);
      check("a5_data", q_at(q0), 32'hA5);
      check("a5_out",  32'(bus.Rx_Data), 32'hA5);
      check("a5_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("a5_busy", 32'(bus.Rx_Busy), 32'h0);
      #BIT;

      // 4-tick low glitch must be rejected
      v0 = valid_cnt; f0 = ferr_cnt;
      @(negedge clk);
      bus.rx = 1'b0;
      #360;
      @(negedge clk);
      check("gl_busy_hi", 32'(bus.Rx_Busy), 32'h1);
      #110;
      bus.rx = 1'b1;
      #960;
      @(negedge clk);
      check("gl_busy_lo", 32'(bus.Rx_Busy), 32'h0);
      check("gl_vcnt",    32'(valid_cnt - v0), 32'd0);
      check("gl_ferr",    32'(ferr_cnt - f0), 32'd0);
      check("gl_data",    32'(bus.Rx_Data), 32'hA5);
      #BIT;

      // framing error: 0x3C with stop low, line low three bit times
      v0 = valid_cnt; f0 = ferr_cnt;
      bus.rx = 1'b0;
      #BIT;
      for (int i = 0; i < 8; i++) begin
         bus.rx = (i >= 2 && i <= 5);
         #BIT;
      end
      bus.rx = 1'b0;
      #(3 * BIT);
      @(negedge clk);
      check("fe_ferr",  32'(ferr_cnt - f0), 32'd1);
      check("fe_vcnt",  32'(valid_cnt - v0), 32'd0);
      check("fe_data",  32'(bus.Rx_Data), 32'hA5);
      check("fe_break", 32'(bus.Rx_Busy), 32'h1);
      bus.rx = 1'b1;
      #(BIT / 2);
      @(negedge clk);
      check("fe_exit",  32'(bus.Rx_Busy), 32'h0);
      #BIT;

      // three frames with no idle between them
      v0 = valid_cnt; f0 = ferr_cnt; q0 = rxq.size();
      send_frame(8'h00, 1'b1, BIT);
      send_frame(8'hFF, 1'b1, BIT);
      send_frame(8'h55, 1'b1, BIT);
      #BIT;
      @(negedge clk);
      check("b2b_vcnt", 32'(valid_cnt - v0), 32'd3);
      check("b2b_d0",   q_at(q0),     32'h00);
      check("b2b_d1",   q_at(q0 + 1), 32'hFF);
      check("b2b_d2",   q_at(q0 + 2), 32'h55);
      check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

      // reset during bit 4 of 0x81, then a full 0x81
      v0 = valid_cnt; q0 = rxq.size();
      bus.rx = 1'b0;
      #BIT;
      for (int i = 0; i < 4; i++) begin
         bus.rx = (i == 0);
         #BIT;
      end
      bus.rx = 1'b0;
      #(BIT / 2);
      reset_n = 1'b0;
      #(BIT / 4);
      bus.rx = 1'b1;
      @(negedge clk);
      check("rm_busy", 32'(bus.Rx_Busy), 32'h0);
      check("rm_data", 32'(bus.Rx_Data), 32'h0);
      reset_n = 1'b1;
      #(2 * BIT);
      @(negedge clk);
      check("rm_quiet", 32'(valid_cnt - v0), 32'd0);
      send_frame(8'h81, 1'b1, BIT);
      #BIT;
      @(negedge clk);
      check("rm_vcnt", 32'(valid_cnt - v0), 32'd1);
      check("rm_d",    q_at(q0), 32'h81);

      // bit period +3% and -3%
      v0 = valid_cnt; q0 = rxq.size();
      send_frame(8'hC3, 1'b1, 1978);
      #BIT;
      send_frame(8'hC3, 1'b1, 1862);
      #BIT;
      @(negedge clk);
      check("sk_vcnt", 32'(valid_cnt - v0), 32'd2);
      check("sk_slow", q_at(q0),     32'hC3);
      check("sk_fast", q_at(q0 + 1), 32'hC3);
      check("sk_out",  32'(bus.Rx_Data), 32'hC3);

      check("pulse_len",  32'(long_cnt), 32'd0);
      check("pulse_both", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
